// File: rtl/topk_pkg.sv
// Shared types and sizing helpers for the top-K tracker and its ranked slots.
package topk_pkg;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_DRAIN   = 1'b1
  } state_t;

  localparam int K_DEFAULT = 4;

  // Width needed to hold an occupancy value in 0..k.
  function automatic int cnt_width(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/topk_slot.sv
// One ranked storage slot: holds a value and valid bit, shifts down on insert
// (taking its upper neighbour) and shifts up on readout (taking its lower one).
module topk_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ins_en,
  input  logic                  shift_up,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  cmp_self,
  input  logic                  cmp_above,
  input  logic [DATA_WIDTH-1:0] val_above,
  input  logic                  vld_above,
  input  logic [DATA_WIDTH-1:0] val_below,
  input  logic                  vld_below,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  vld
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value <= '0;
      vld   <= 1'b0;
    end else if (clear) begin
      value <= '0;
      vld   <= 1'b0;
    end else if (shift_up) begin
      value <= val_below;
      vld   <= vld_below;
    end else if (ins_en) begin
      // The insert point is the first qualifying slot; everything below it moves down.
      if (cmp_above) begin
        value <= val_above;
        vld   <= vld_above;
      end else if (cmp_self) begin
        value <= din;
        vld   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/topk_drain.sv
// Streaming top-K tracker: keeps the K largest unsigned samples sorted and,
// on flush, streams them largest-first over a valid/ready port.
module topk_drain
  import topk_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int K          = K_DEFAULT
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [cnt_width(K)-1:0] count,
  output logic                    state_dbg
);

  localparam int CW = cnt_width(K);

  // Handshake: a beat moves on a rising edge only when valid and ready are both
  // high; valid never depends on ready, and data/last hold while valid waits.

  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  logic [DATA_WIDTH-1:0] slot_val [K];
  logic [K-1:0]          slot_vld;
  logic [K-1:0]          cmp;
  logic [K-1:0]          cmp_up;
  logic [DATA_WIDTH-1:0] val_ext  [K+2];
  logic [K+1:0]          vld_ext;

  logic accept, xfer, shift_up, clear;

  assign accept = din_valid && (state_q == ST_COLLECT);
  assign xfer   = out_ready && (state_q == ST_DRAIN);

  // Neighbour views padded with empty entries above slot 0 and below slot K-1.
  always_comb begin
    val_ext[0]    = '0;
    val_ext[K+1]  = '0;
    vld_ext[0]    = 1'b0;
    vld_ext[K+1]  = 1'b0;
    for (int i = 0; i < K; i++) begin
      val_ext[i+1] = slot_val[i];
      vld_ext[i+1] = slot_vld[i];
      cmp[i]       = !slot_vld[i] || (din > slot_val[i]);
    end
  end

  assign cmp_up = {cmp[K-2:0], 1'b0};

  for (genvar g = 0; g < K; g++) begin : g_slot
    topk_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk       (clk),
      .resetn    (resetn),
      .ins_en    (accept),
      .shift_up  (shift_up),
      .clear     (clear),
      .din       (din),
      .cmp_self  (cmp[g]),
      .cmp_above (cmp_up[g]),
      .val_above (val_ext[g]),
      .vld_above (vld_ext[g]),
      .val_below (val_ext[g+2]),
      .vld_below (vld_ext[g+2]),
      .value     (slot_val[g]),
      .vld       (slot_vld[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shift_up = 1'b0;
    clear    = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        // cmp[K-1] is set whenever any slot qualifies, since ranks are monotonic.
        if (accept && cmp[K-1] && (count_q != CW'(K))) count_d = count_q + 1'b1;
        // A same-cycle accept always lands, so it alone makes the batch non-empty.
        if (flush && ((count_q != '0) || accept)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (xfer) begin
          shift_up = 1'b1;
          count_d  = count_q - 1'b1;
          if (count_q == CW'(1)) begin
            clear   = 1'b1;
            count_d = '0;
            state_d = ST_COLLECT;
          end
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_COLLECT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign din_ready = (state_q == ST_COLLECT);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_last  = (state_q == ST_DRAIN) && (count_q == CW'(1));
  assign out_data  = slot_val[0];
  assign count     = count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_topk_drain.sv
// Bench for topk_drain (DATA_WIDTH=8, K=4): queue-based reference model checked
// every cycle, plus directed scenarios with literal beat expectations.
module tb_topk_drain;

  localparam int DW = 8;
  localparam int K  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic          flush;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [CW-1:0] count;
  logic          state_dbg;

  topk_drain #(.DATA_WIDTH(DW), .K(K)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .count     (count),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a descending queue of at most K kept samples.
  logic [DW-1:0] m_q[$];
  logic          m_drain;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_q.delete();
      m_drain = 1'b0;
    end else if (!m_drain) begin
      if (din_valid) begin
        int pos;
        pos = m_q.size();
        for (int i = 0; i < m_q.size(); i++) begin
          if (din > m_q[i]) begin
            pos = i;
            break;
          end
        end
        if (pos < K) begin
          m_q.insert(pos, din);
          if (m_q.size() > K) m_q.delete(K);
        end
      end
      if (flush && m_q.size() != 0) m_drain = 1'b1;
    end else if (out_ready) begin
      m_q.delete(0);
      if (m_q.size() == 0) m_drain = 1'b0;
    end
  end

  // Compare process: every falling edge, outputs against the model.
  always @(negedge clk) begin
    check("din_ready", din_ready, !m_drain);
    check("out_valid", out_valid, m_drain);
    check("state_dbg", state_dbg, m_drain);
    check("count", count, m_q.size());
    check("out_last", out_last, m_drain && (m_q.size() == 1));
    if (m_drain) check("out_data", out_data, m_q[0]);
  end

  // Scoreboard of transferred beats, compared against hand-computed lists.
  logic [DW-1:0] got_q[$];
  logic          got_last_q[$];
  int            got_cyc_q[$];
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];

  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_last_q.push_back(out_last);
      got_cyc_q.push_back(cyc);
    end
  end

  task automatic expect_beat(input logic [DW-1:0] v, input logic last);
    exp_q.push_back(v);
    exp_last_q.push_back(last);
  endtask

  task automatic check_beats(input string name);
    check({name, "_nbeats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({name, "_data"}, got_q[i], exp_q[i]);
      check({name, "_last"}, got_last_q[i], exp_last_q[i]);
      check({name, "_gap"}, got_cyc_q[i] - got_cyc_q[0], i);
    end
    got_q.delete();
    got_last_q.delete();
    got_cyc_q.delete();
    exp_q.delete();
    exp_last_q.delete();
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] v);
    din       = v;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    resetn    = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_din_ready", din_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_count", count, 0);
    resetn = 1'b1;
    tick();

    // 1: overflow discards the smallest
    send(8'd5); send(8'd9); send(8'd3); send(8'd7); send(8'd1);
    check("s1_count_full", count, 4);
    do_flush();
    check("s1_first", out_data, 9);
    repeat (5) tick();
    expect_beat(8'd9, 0); expect_beat(8'd7, 0); expect_beat(8'd5, 0); expect_beat(8'd3, 1);
    check_beats("s1");
    check("s1_back_ready", din_ready, 1);

    // 2: equal values
    send(8'd4); send(8'd4); send(8'd2);
    check("s2_count", count, 3);
    do_flush();
    repeat (4) tick();
    expect_beat(8'd4, 0); expect_beat(8'd4, 0); expect_beat(8'd2, 1);
    check_beats("s2");

    // 3: backpressure
    out_ready = 1'b0;
    send(8'd10); send(8'd20);
    do_flush();
    for (int i = 0; i < 3; i++) begin
      check("s3_hold_data", out_data, 20);
      check("s3_hold_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    repeat (3) tick();
    expect_beat(8'd20, 0); expect_beat(8'd10, 1);
    check_beats("s3");

    // 4: empty flush ignored
    do_flush();
    check("s4_out_valid", out_valid, 0);
    check("s4_din_ready", din_ready, 1);
    check("s4_state", state_dbg, 0);
    tick();

    // 5: accept with flush, sample during drain refused
    send(8'd6);
    din = 8'd8; din_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    din = 8'd55;
    check("s5_din_ready", din_ready, 0);
    check("s5_first", out_data, 8);
    tick();
    din_valid = 1'b0;
    repeat (2) tick();
    expect_beat(8'd8, 0); expect_beat(8'd6, 1);
    check_beats("s5");
    check("s5_count", count, 0);

    // 6: asynchronous reset mid-drain
    send(8'd1); send(8'd2); send(8'd3);
    do_flush();
    tick();
    expect_beat(8'd3, 0);
    check_beats("s6");
    #2 resetn = 1'b0;
    #1;
    check("s6_async_valid", out_valid, 0);
    check("s6_async_count", count, 0);
    check("s6_async_ready", din_ready, 1);
    check("s6_async_data", out_data, 0);
    tick();
    resetn = 1'b1;
    send(8'd9);
    check("s6_count_after", count, 1);
    check("s6_data_after", out_data, 9);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/topk_drain.md
# topk_drain

Streaming top-K tracker with a handshaked readout port. While collecting, it keeps the K largest samples seen on a valid-qualified input stream, sorted in registers. On a flush request it sends those samples largest-first over a valid/ready output stream, then clears itself for the next batch. It is the reader end of the running-statistics path: the running-statistics blocks only expose the current extreme values, while this block produces the ranked result as a sequence of transfers.

## Interface
- `DATA_WIDTH`, 32: sample width, unsigned.
- `K`, 4: number of ranked slots; legal range is 2..16.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset; asynchronous and active-low.
- `din`  in  DATA_WIDTH  input sample.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  block accepts samples; 1 in COLLECT, 0 in DRAIN.
- `flush`  in  1  single-cycle request to start readout; sampled only in COLLECT.
- `out_data`  out  DATA_WIDTH  current ranked sample, driven directly from slot 0.
- `out_valid`  out  1  `out_data` is valid; high only in DRAIN.
- `out_ready`  in  1  downstream accepts the beat.
- `out_last`  out  1  the current beat is the final entry of this batch.
- `count`  out  $clog2(K+1)  number of occupied slots.

## Operation
- Storage is `slot[0..K-1]` with `vld[0..K-1]`. `slot[0]` holds the largest value. Occupied slots are always contiguous from index 0.
- FSM has two states, COLLECT and DRAIN. Reset state is COLLECT.
- Insert rule: a sample is accepted when `din_valid` and `din_ready` are both 1.
  - Insert position p is the lowest index where `vld[i]==0` or `din > slot[i]` (strictly greater).
  - Entries p..K-2 shift down one slot, and `slot[K-1]` is dropped when full.
  - Because the comparison is strict, equal values are placed below existing equals.
  - If no position qualifies (full and `din` ≤ `slot[K-1]`), the sample is discarded with no state change.
- `count` increments on insert, saturates at K, and is unchanged on discard.
- COLLECT→DRAIN: `flush==1` and `count!=0`. A flush with `count==0` is ignored.
- Accept and flush in the same cycle: the sample is inserted first, and the drain includes it.
- DRAIN:
  - `out_valid=1`, `out_data=slot[0]`, `out_last=(count==1)`.
  - On `out_valid && out_ready`: slots shift up by one, the vacated top-index `vld` clears, and `count` decrements.
  - A transfer with `out_last=1` returns the FSM to COLLECT with all `vld` cleared and `count=0`.
- `flush` asserted during DRAIN is ignored.
- Comparisons are unsigned and full width. There is no arithmetic beyond the increment/decrement of `count`.

## Timing
- Reset values: `din_ready=1`, `out_valid=0`, `out_last=0`, `out_data=0`, `count=0`, all `slot=0`, all `vld=0`.
- An asynchronous reset asserted mid-drain forces these values immediately, without waiting for a clock edge. Any partial batch is lost.
- Insert latency is 1 cycle: an accept at edge N is reflected in `slot`/`count` after edge N.
- Flush sampled at edge N gives `din_ready=0` and `out_valid=1` from cycle N+1.
- With `out_ready` held high, the drain produces one beat per cycle with no bubbles. The FSM is back in COLLECT, with `din_ready=1`, the cycle after the last beat.
- While `out_ready=0`, `out_data` and `out_last` hold stable, and `out_valid` never drops before the transfer completes.
- The outputs `din_ready`, `out_valid` and `out_last` are decoded from registered state only, with no combinational path from inputs. `out_data` is `slot[0]`.

## Structure
- Package `topk_pkg` holds:
  - the state enum (`ST_COLLECT`, `ST_DRAIN`);
  - the default `K`;
  - a function computing the `count` width.
- One sub-module, `topk_slot`, instantiated K times. Each slot holds its value and valid bit and takes these inputs:
  - its own compare result;
  - the upper neighbour's compare result;
  - the upper neighbour's value, for shift-down;
  - the lower neighbour's value, for shift-up.
- The top level contains the FSM, the `count` logic and the output decode.

## Test plan
All scenarios use `DATA_WIDTH=8`, `K=4`.
- Insert 5,9,3,7,1, then flush with `out_ready=1` → beats 9,7,5,3 on consecutive cycles; `out_last` on 3; `count` goes 4→0.
- Insert 4,4,2, flush → beats 4,4,2; `out_last` on 2; `count` is 3 at the flush.
- Insert 10,20, flush, hold `out_ready=0` for 3 cycles → `out_data=20` stable and `out_valid=1` throughout; release → 20, then 10 with `out_last`.
- Flush with nothing inserted → `out_valid` stays 0; `din_ready` stays 1; FSM remains in COLLECT.
- Insert 6, then present `din=8`, `din_valid=1` and `flush=1` together → beats 8,6. A sample presented during DRAIN is not accepted (`din_ready=0`).
- Insert 1,2,3, flush, drop `resetn` after the first beat → `out_valid=0` and `count=0` asynchronously. After reset, a new insert of 9 gives `count=1`.
